hqm_aw_residue_accum: RTL and testbench
=======================================

# hqm_AW_residue_accum

Residue-protected streaming accumulator for the AW library. It sums a stream of WIDTH-bit data beats, each carrying a 2-bit mod-3 residue, and emits the total with its residue on the last beat of each group. Incoming residues are checked on entry. The running residue is maintained by mod-3 addition rather than regenerated, so a datapath fault surfaces as a residue mismatch. It sits upstream of the residue adders and checkers that consume out_res.

## Interface
- WIDTH, 16, data width; must be even, 2..64, so that 2^WIDTH ≡ 1 mod 3.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_v  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_v && in_ready
- in_data  in  WIDTH  beat data
- in_res  in  2  mod-3 residue of in_data; 3 is illegal
- in_last  in  1  final beat of group
- out_v  out  1  group total valid
- out_ready  in  1  consumer accepts when out_v && out_ready
- out_data  out  WIDTH  group sum mod 2^WIDTH
- out_res  out  2  mod-3 residue of out_data
- err_in  out  1  one-cycle pulse: input residue mismatch or illegal
- err_acc  out  1  one-cycle pulse: internal residue check failed
- err_sticky  out  1  OR of all error pulses since reset

## Operation
- Residue generation: residue(x) is the sum of the 2-bit chunks of x, reduced mod 3 (4 ≡ 1). The result is always in 0..2.
- Stall: stall = out_v && !out_ready. in_ready = !stall.
- Stage P1: on accept, register p1_v, p1_data, p1_res, p1_last. When not stalled and nothing is accepted, p1_v clears. During a stall, P1 holds.
- P1 check: if p1_v && (p1_res == 3 || residue(p1_data) != p1_res), pulse err_in. Data is still accumulated using p1_res as supplied, so the fault propagates to downstream checkers.
- Stage P2 (when p1_v && !stall):
  - sum = acc + p1_data, with carry c (bit WIDTH).
  - nres = acc_res +3 p1_res +3 (c ? 2 : 0). Wrap removes 2^WIDTH ≡ 1.
  - !p1_last: acc <= sum[WIDTH-1:0]; acc_res <= nres.
  - p1_last: out_data <= sum[WIDTH-1:0]; out_res <= nres; out_v <= 1; acc <= 0; acc_res <= 0.
- Output: out_v clears on out_v && out_ready, unless a new total loads in the same cycle. No loading occurs while out_v && !out_ready. out_data and out_res are held stable while out_v && !out_ready.
- Internal check, every cycle:
  - err_acc pulses if residue(acc) != acc_res.
  - err_acc also pulses if out_v && residue(out_data) != out_res.
- err_sticky sets on any err_in or err_acc pulse and clears only on reset.
- The single-beat group case (in_last on the first beat) is legal. out_data = in_data.

## Timing
- Reset values:
  - in_ready 1, out_v 0, out_data 0, out_res 0.
  - err_in 0, err_acc 0, err_sticky 0.
  - acc 0, acc_res 0, p1_v 0.
- Latency: last beat accepted in cycle t gives out_v in cycle t+2. The error pulses err_in and err_acc are registered and appear in cycle t+2 for a beat accepted in cycle t.
- Throughput: one beat per cycle while not stalled. A new group may start in the cycle after the last beat.
- Backpressure:
  - in_ready drops combinationally from out_v && !out_ready.
  - In-flight P1 holds; nothing is lost or duplicated.
  - in_ready does not depend on in_v.
- out_v && out_ready with a new last beat in P1 in the same cycle: the new total loads; out_v stays 1.
- Reset mid-group: the partial sum is discarded and the next accepted beat starts a new group.

## Test plan
- Basic group (WIDTH=16): beats 5/res2, 7/res1, 3/res0/last with out_ready=1.
  - out_v=1 two cycles after the last beat, out_data=15, out_res=0.
  - No error pulses.
- Wrap: 0xFFFF/res0, then 0x0002/res2/last.
  - out_data=0x0001, out_res=1, err_acc=0.
- Bad residue: 4/res0/last.
  - err_in pulses two cycles after accept; err_sticky=1.
  - out_data=4, out_res=0.
  - err_acc pulses while out_v is held.
- Illegal residue: 6/res3/last.
  - err_in pulses; err_sticky=1.
- Backpressure:
  - out_ready=0 while out_v=1: in_ready=0, and out_data/out_res are stable for 5 cycles.
  - Raise out_ready: accepts resume, and the next group total is correct and emitted exactly once.
- Reset: deassert rst_n after two beats of a group.
  - All outputs return to their reset values.
  - A following group 1/res1/last gives out_data=1, out_res=1.

Source files
------------

// File: rtl/hqm_aw_residue_accum.sv
// Residue-protected streaming accumulator: sums WIDTH-bit beats per group, carrying a
// mod-3 residue alongside the sum so datapath faults surface downstream as mismatches.
module hqm_aw_residue_accum #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_v_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [1:0]       in_res_i,
    input  logic             in_last_i,
    output logic             out_v_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       out_res_o,
    output logic             err_in_o,
    output logic             err_acc_o,
    output logic             err_sticky_o
);

    localparam int NCHUNK = int'(WIDTH / 2);
    localparam int unsigned RSUM_W = 8;

    // Sum of 2-bit chunks reduced mod 3; valid because 4 == 1 (mod 3).
    function automatic logic [1:0] residue(input logic [WIDTH-1:0] x);
        logic [RSUM_W-1:0] s;
        s = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            s = s + RSUM_W'(x[2*i +: 2]);
        end
        return 2'(s % RSUM_W'(3));
    endfunction

    logic             p1_v_q, p1_v_d;
    logic [WIDTH-1:0] p1_data_q, p1_data_d;
    logic [1:0]       p1_res_q, p1_res_d;
    logic             p1_last_q, p1_last_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [1:0]       acc_res_q, acc_res_d;
    logic             out_v_q, out_v_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [1:0]       out_res_q, out_res_d;
    logic             err_in_q, err_in_d;
    logic             err_acc_q, err_acc_d;
    logic             err_sticky_q, err_sticky_d;

    logic             stall_c;
    logic             accept_c;
    logic             fire_c;
    logic [WIDTH:0]   sum_c;
    logic [3:0]       nres_raw_c;
    logic [1:0]       nres_c;

    assign stall_c    = out_v_q && !out_ready_i;
    assign in_ready_o = !stall_c;
    assign accept_c   = in_v_i && !stall_c;
    assign fire_c     = p1_v_q && !stall_c;

    // Carry out of the adder removes 2^WIDTH == 1 (mod 3), i.e. adds 2.
    assign sum_c      = {1'b0, acc_q} + {1'b0, p1_data_q};
    assign nres_raw_c = 4'(acc_res_q) + 4'(p1_res_q) + (sum_c[WIDTH] ? 4'd2 : 4'd0);
    assign nres_c     = 2'(nres_raw_c % 4'd3);

    always_comb begin
        p1_v_d       = p1_v_q;
        p1_data_d    = p1_data_q;
        p1_res_d     = p1_res_q;
        p1_last_d    = p1_last_q;
        acc_d        = acc_q;
        acc_res_d    = acc_res_q;
        out_v_d      = out_v_q;
        out_data_d   = out_data_q;
        out_res_d    = out_res_q;
        err_in_d     = 1'b0;
        err_acc_d    = 1'b0;

        if (accept_c) begin
            p1_v_d    = 1'b1;
            p1_data_d = in_data_i;
            p1_res_d  = in_res_i;
            p1_last_d = in_last_i;
        end else if (!stall_c) begin
            p1_v_d    = 1'b0;
        end

        if (out_v_q && out_ready_i) begin
            out_v_d = 1'b0;
        end

        // Faulty residues are still accumulated so downstream checkers see them.
        if (fire_c) begin
            err_in_d = (p1_res_q == 2'd3) || (residue(p1_data_q) != p1_res_q);
            if (p1_last_q) begin
                out_v_d    = 1'b1;
                out_data_d = sum_c[WIDTH-1:0];
                out_res_d  = nres_c;
                acc_d      = '0;
                acc_res_d  = '0;
            end else begin
                acc_d      = sum_c[WIDTH-1:0];
                acc_res_d  = nres_c;
            end
        end

        if (residue(acc_q) != acc_res_q) begin
            err_acc_d = 1'b1;
        end
        if (out_v_q && (residue(out_data_q) != out_res_q)) begin
            err_acc_d = 1'b1;
        end

        err_sticky_d = err_sticky_q || err_in_d || err_acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1_v_q       <= 1'b0;
            p1_data_q    <= '0;
            p1_res_q     <= '0;
            p1_last_q    <= 1'b0;
            acc_q        <= '0;
            acc_res_q    <= '0;
            out_v_q      <= 1'b0;
            out_data_q   <= '0;
            out_res_q    <= '0;
            err_in_q     <= 1'b0;
            err_acc_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            p1_v_q       <= p1_v_d;
            p1_data_q    <= p1_data_d;
            p1_res_q     <= p1_res_d;
            p1_last_q    <= p1_last_d;
            acc_q        <= acc_d;
            acc_res_q    <= acc_res_d;
            out_v_q      <= out_v_d;
            out_data_q   <= out_data_d;
            out_res_q    <= out_res_d;
            err_in_q     <= err_in_d;
            err_acc_q    <= err_acc_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign out_v_o      = out_v_q;
    assign out_data_o   = out_data_q;
    assign out_res_o    = out_res_q;
    assign err_in_o     = err_in_q;
    assign err_acc_o    = err_acc_q;
    assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_hqm_aw_residue_accum.sv
// Directed bench for hqm_aw_residue_accum: basic group, wrap, bad/illegal residue,
// backpressure hold and mid-group reset, with hand-computed expectations.
module tb_hqm_aw_residue_accum;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_v;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [1:0]   in_res;
    logic         in_last;
    logic         out_v;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic [1:0]   out_res;
    logic         err_in;
    logic         err_acc;
    logic         err_sticky;

    int errors = 0;
    int checks = 0;

    hqm_aw_residue_accum #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_v_i      (in_v),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_res_i    (in_res),
        .in_last_i   (in_last),
        .out_v_o     (out_v),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_res_o   (out_res),
        .err_in_o    (err_in),
        .err_acc_o   (err_acc),
        .err_sticky_o(err_sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [1:0] r, input logic l);
        in_v    = v;
        in_data = d;
        in_res  = r;
        in_last = l;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_v"}, 64'(out_v), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_res"}, 64'(out_res), 64'd0);
        chk({tag, "_err_in"}, 64'(err_in), 64'd0);
        chk({tag, "_err_acc"}, 64'(err_acc), 64'd0);
        chk({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, 2'd0, 1'b0);
        tick();
        tick();
        chk_reset_vals("por");
        rst_n = 1'b1;

        // Basic group 5+7+3 followed back-to-back by wrap group 0xFFFF+0x0002.
        drive(1'b1, 16'd5, 2'd2, 1'b0);
        tick();
        drive(1'b1, 16'd7, 2'd1, 1'b0);
        tick();
        drive(1'b1, 16'd3, 2'd0, 1'b1);
        tick();
        drive(1'b1, 16'hFFFF, 2'd0, 1'b0);
        chk("basic_not_early", 64'(out_v), 64'd0);
        tick();
        chk("basic_out_v", 64'(out_v), 64'd1);
        chk("basic_out_data", 64'(out_data), 64'd15);
        chk("basic_out_res", 64'(out_res), 64'd0);
        chk("basic_err_in", 64'(err_in), 64'd0);
        chk("basic_err_acc", 64'(err_acc), 64'd0);
        drive(1'b1, 16'h0002, 2'd2, 1'b1);
        tick();
        chk("basic_out_v_clr", 64'(out_v), 64'd0);
        drive(1'b0, '0, 2'd0, 1'b0);
        tick();
        chk("wrap_out_v", 64'(out_v), 64'd1);
        chk("wrap_out_data", 64'(out_data), 64'h0001);
        chk("wrap_out_res", 64'(out_res), 64'd1);
        chk("wrap_err_acc", 64'(err_acc), 64'd0);
        tick();
        chk("wrap_out_v_clr", 64'(out_v), 64'd0);
        chk("wrap_err_acc2", 64'(err_acc), 64'd0);
        chk("wrap_err_in", 64'(err_in), 64'd0);
        chk("wrap_sticky", 64'(err_sticky), 64'd0);

        // Illegal residue code 3 on a single-beat group.
        drive(1'b1, 16'd6, 2'd3, 1'b1);
        tick();
        drive(1'b0, '0, 2'd0, 1'b0);
        chk("ill_no_early_err", 64'(err_in), 64'd0);
        tick();
        chk("ill_err_in", 64'(err_in), 64'd1);
        chk("ill_sticky", 64'(err_sticky), 64'd1);
        chk("ill_out_data", 64'(out_data), 64'd6);
        chk("ill_out_res", 64'(out_res), 64'd0);
        tick();
        chk("ill_err_in_pulse", 64'(err_in), 64'd0);
        chk("ill_sticky_hold", 64'(err_sticky), 64'd1);

        // Reset after two beats of a group; partial sum must be discarded.
        drive(1'b1, 16'd5, 2'd2, 1'b0);
        tick();
        drive(1'b1, 16'd7, 2'd1, 1'b0);
        tick();
        drive(1'b0, '0, 2'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b1, 16'd1, 2'd1, 1'b1);
        tick();
        drive(1'b0, '0, 2'd0, 1'b0);
        tick();
        chk("postrst_out_v", 64'(out_v), 64'd1);
        chk("postrst_out_data", 64'(out_data), 64'd1);
        chk("postrst_out_res", 64'(out_res), 64'd1);
        chk("postrst_err_in", 64'(err_in), 64'd0);
        tick();
        chk("postrst_out_v_clr", 64'(out_v), 64'd0);

        // Bad residue held under backpressure, then a stalled group released.
        out_ready = 1'b0;
        drive(1'b1, 16'd4, 2'd0, 1'b1);
        tick();
        drive(1'b0, '0, 2'd0, 1'b0);
        tick();
        chk("bad_out_v", 64'(out_v), 64'd1);
        chk("bad_out_data", 64'(out_data), 64'd4);
        chk("bad_out_res", 64'(out_res), 64'd0);
        chk("bad_err_in", 64'(err_in), 64'd1);
        chk("bad_sticky", 64'(err_sticky), 64'd1);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 16'd10, 2'd1, 1'b1);
        tick();
        chk("bad_err_acc", 64'(err_acc), 64'd1);
        chk("bad_err_in_pulse", 64'(err_in), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_out_v", 64'(out_v), 64'd1);
            chk("bp_hold_out_data", 64'(out_data), 64'd4);
            chk("bp_hold_out_res", 64'(out_res), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
        tick();
        drive(1'b0, '0, 2'd0, 1'b0);
        chk("bp_old_cleared", 64'(out_v), 64'd0);
        tick();
        chk("bp_new_out_v", 64'(out_v), 64'd1);
        chk("bp_new_out_data", 64'(out_data), 64'd10);
        chk("bp_new_out_res", 64'(out_res), 64'd1);
        chk("bp_new_err_in", 64'(err_in), 64'd0);
        tick();
        chk("bp_once_a", 64'(out_v), 64'd0);
        tick();
        chk("bp_once_b", 64'(out_v), 64'd0);
        chk("bp_sticky_final", 64'(err_sticky), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
